// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed data memory with asynchronous read.
// One request at a time: IDLE -> (LOAD | WRITE) -> RESP, or IDLE -> RESP directly for errors.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        dm_write,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic [1:0]  dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high.
   // The request side transfers only in IDLE; the response is held until resp_ready.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        lat_store;
   logic [2:0]  lat_funct3;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        req_fire;
   logic        funct3_illegal;
   logic        misaligned;
   logic        out_of_range;
   logic        req_err;

   logic [31:0] lane_shifted;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;

   assign dbg_state = state;
   assign dm_addr   = {lat_addr[31:2], 2'b00};
   assign req_fire  = req_valid && req_ready;

   // Request legality is judged on the live inputs so the error path can skip straight to RESP.
   always_comb begin
      funct3_illegal = 1'b0;
      if (req_store) begin
         funct3_illegal = (req_funct3 > 3'd2);
      end else begin
         funct3_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      end
      misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      out_of_range = (req_addr >= 32'(MEM_BYTES));
      req_err      = funct3_illegal || misaligned || out_of_range;
   end

   always_comb begin
      lane_shifted = dm_rdata >> {lat_addr[1:0], 3'b000};
      load_byte    = lane_shifted[7:0];
      load_half    = lat_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (lat_funct3)
         3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_data = {24'd0, load_byte};
         3'b001:  load_data = {{16{load_half[15]}}, load_half};
         3'b101:  load_data = {16'd0, load_half};
         default: load_data = dm_rdata;
      endcase
   end

   // Read-modify-write: untouched lanes come straight from the current memory word.
   always_comb begin
      dm_wdata = dm_rdata;
      case (lat_funct3[1:0])
         2'b00: begin
            case (lat_addr[1:0])
               2'b00:   dm_wdata[7:0]   = lat_wdata[7:0];
               2'b01:   dm_wdata[15:8]  = lat_wdata[7:0];
               2'b10:   dm_wdata[23:16] = lat_wdata[7:0];
               default: dm_wdata[31:24] = lat_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (lat_addr[1]) begin
               dm_wdata[31:16] = lat_wdata[15:0];
            end else begin
               dm_wdata[15:0] = lat_wdata[15:0];
            end
         end
         default: dm_wdata = lat_wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_fire) begin
               if (req_err) begin
                  state_next = RESP;
               end else if (req_store) begin
                  state_next = WRITE;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD:    state_next = RESP;
         WRITE:   state_next = RESP;
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE) && !reset;
      dm_write   = (state == WRITE) && !reset;
      resp_valid = (state == RESP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_store  <= 1'b0;
         lat_funct3 <= 3'd0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  lat_store  <= req_store;
                  lat_funct3 <= req_funct3;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata;
                  resp_rdata <= 32'd0;
                  resp_err   <= req_err;
               end
            end
            LOAD: begin
               resp_rdata <= load_data;
            end
            default: begin
            end
         endcase
      end
   end

   // lat_store is kept for debug visibility of the accepted request.
   logic unused_lat_store;
   assign unused_lat_store = lat_store;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-array reference model.
// The bench also plays the attached data memory (async read, write on rising edge).
module tb_load_store_unit;

   localparam int MEM_BYTES = 1024;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        dm_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic [1:0]  dbg_state;

   logic [31:0] mem [0:255];
   logic [7:0]  ref_mem [0:MEM_BYTES-1];
   int          wr_cnt;
   int          exp_wr;
   int          n_assert;
   int          n_fail;
   logic [31:0] last_rdata;

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .dm_write   (dm_write),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_rdata   (dm_rdata),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_rdata = mem[dm_addr[9:2]];

   always @(posedge clk) begin
      if (dm_write === 1'b1) begin
         mem[dm_addr[9:2]] <= dm_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      int unsigned size;
      if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      size = 1 << f3[1:0];
      return !legal || ((a % size) != 0) || (a >= MEM_BYTES);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      int          n;
      logic [31:0] v;
      logic [31:0] mask;
      n = 1 << f3[1:0];
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (n < 4 && !f3[2]) begin
         mask = (32'd1 << (8 * n)) - 32'd1;
         if (v[8 * n - 1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 1 << f3[1:0];
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(d >> (8 * i));
   endtask

   task automatic transact(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int delay);
      bit          err;
      logic [31:0] exp_rd;
      err    = model_err(st, f3, addr);
      exp_rd = 32'd0;
      if (!err && !st) exp_rd = model_load(f3, addr);
      if (!err && st) begin
         model_store(f3, addr, wd);
         exp_wr++;
      end
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = 1'b0;
      @(posedge clk);
      #1;
      // A legal store kept on the bus while busy; it must never be taken.
      req_store  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'($urandom_range(0, 255)) << 2;
      req_wdata  = $urandom;
      if (!err) begin
         @(negedge clk);
         chk("resp_valid_early", 32'(resp_valid), 32'd0);
         chk("req_ready_busy", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_err", 32'(resp_err), 32'(err));
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("req_ready_resp", 32'(req_ready), 32'd0);
      last_rdata = resp_rdata;
      repeat (delay) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_rdata", resp_rdata, exp_rd);
         chk("hold_err", 32'(resp_err), 32'(err));
         chk("hold_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk("write_count", 32'(wr_cnt), 32'(exp_wr));
   endtask

   initial begin
      logic [31:0] w;
      n_assert   = 0;
      n_fail     = 0;
      wr_cnt     = 0;
      exp_wr     = 0;
      last_rdata = 32'd0;
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         mem[i] = w;
         for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = 8'(w >> (8 * b));
      end
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      resp_ready = 1'b0;

      // Reset state, including the combinational gating while reset is high.
      repeat (3) @(negedge clk);
      req_valid = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_dm_write", 32'(dm_write), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      req_valid = 1'b0;
      reset     = 1'b0;

      // Word store/load round trip, then byte and half lane updates.
      transact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
      transact(1'b0, 3'b010, 32'h10, 32'd0, 0);
      chk("lw_deadbeef", last_rdata, 32'hDEADBEEF);
      transact(1'b1, 3'b000, 32'h12, 32'h00000055, 0);
      transact(1'b0, 3'b010, 32'h10, 32'd0, 0);
      chk("lw_after_sb", last_rdata, 32'hDE55BEEF);
      transact(1'b0, 3'b000, 32'h12, 32'd0, 0);
      chk("lb_12", last_rdata, 32'h00000055);
      transact(1'b0, 3'b000, 32'h13, 32'd0, 0);
      chk("lb_13", last_rdata, 32'hFFFFFFDE);
      transact(1'b0, 3'b100, 32'h13, 32'd0, 0);
      chk("lbu_13", last_rdata, 32'h000000DE);
      transact(1'b1, 3'b001, 32'h12, 32'h00008001, 0);
      transact(1'b0, 3'b001, 32'h12, 32'd0, 0);
      chk("lh_12", last_rdata, 32'hFFFF8001);
      transact(1'b0, 3'b101, 32'h12, 32'd0, 0);
      chk("lhu_12", last_rdata, 32'h00008001);
      transact(1'b0, 3'b010, 32'h10, 32'd0, 0);
      chk("lw_after_sh", last_rdata, 32'h8001BEEF);

      // Error requests: misaligned, out of range, illegal funct3.
      transact(1'b0, 3'b010, 32'h11, 32'd0, 0);
      transact(1'b1, 3'b001, 32'h13, 32'h0000AAAA, 0);
      transact(1'b1, 3'b010, 32'h400, 32'h11111111, 0);
      transact(1'b0, 3'b011, 32'h10, 32'd0, 0);
      transact(1'b1, 3'b100, 32'h14, 32'h22222222, 0);

      // Back-pressure on the response with a competing request on the bus.
      transact(1'b0, 3'b010, 32'h10, 32'd0, 5);
      chk("lw_hold", last_rdata, 32'h8001BEEF);

      // Reset during WRITE suppresses the write and clears the response path.
      transact(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0);
      @(negedge clk);
      chk("req_ready_pre_wr", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_store  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      req_wdata  = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("wr_strobe_pre_rst", 32'(dm_write), 32'd1);
      reset = 1'b1;
      #1;
      chk("wr_strobe_rst", 32'(dm_write), 32'd0);
      chk("wr_ready_rst", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("wr_rst_valid", 32'(resp_valid), 32'd0);
      chk("wr_rst_err", 32'(resp_err), 32'd0);
      chk("wr_rst_rdata", resp_rdata, 32'd0);
      chk("wr_rst_count", 32'(wr_cnt), 32'(exp_wr));
      reset = 1'b0;
      transact(1'b0, 3'b010, 32'h20, 32'd0, 0);
      chk("lw_20_prior", last_rdata, 32'hCAFEF00D);

      // Reset during LOAD discards the pending response.
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("ld_rst_valid", 32'(resp_valid), 32'd0);
      chk("ld_rst_rdata", resp_rdata, 32'd0);
      reset = 1'b0;

      // Randomized mix, biased toward legal in-range accesses with some edge addresses.
      for (int t = 0; t < 120; t++) begin
         logic [31:0] a;
         logic [2:0]  f;
         bit          s;
         s = 1'($urandom_range(0, 1));
         f = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 8));
         else if ($urandom_range(0, 19) == 0) a = $urandom;
         else a = 32'($urandom_range(0, MEM_BYTES - 1));
         if ($urandom_range(0, 3) != 0) begin
            if (s) f = 3'($urandom_range(0, 2));
            a = a & ~((32'd1 << f[1:0]) - 32'd1);
         end
         transact(s, f, a, $urandom, int'($urandom_range(0, 2)));
      end

      @(negedge clk);
      chk("final_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 256; i++) begin
         chk("mem_contents", mem[i],
             {ref_mem[4 * i + 3], ref_mem[4 * i + 2], ref_mem[4 * i + 1], ref_mem[4 * i]});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
